divu_seq_ctrl: RTL and testbench
================================

// Module: divu_seq_ctrl
// PURPOSE
// - Sequencing controller for the MIPS HI/LO divide unit: accepts DIV/DIVU/MTHI/MTLO from decode.
// - Runs a 1-bit/cycle shift-subtract core, applies the signed fix-up, and writes HI (remainder) and LO (quotient).
// - Drives stall back to the single-cycle datapath while a divide is in flight.
// - Replaces the free-running, self-clocked divider with a clk/reset_n-synchronous start/done sequence.
// PARAMETERS
// - WIDTH  32  operand/HI/LO width; iteration count = WIDTH.
// PORTS
// - clk       in   1      system clock, rising edge
// - reset_n   in   1      asynchronous, active-low reset
// - op_valid  in   1      decode presents a HI/LO-writing op this cycle
// - op_code   in   2      mdu_op_t: 0 DIVU, 1 DIV, 2 MTHI, 3 MTLO
// - rs_val    in   WIDTH  dividend / MTHI-MTLO source
// - rt_val    in   WIDTH  divisor
// - mf_req    in   1      decode is executing MFHI/MFLO this cycle
// - flush     in   1      synchronous abort of the in-flight divide
// - hi        out  WIDTH  HI register (remainder)
// - lo        out  WIDTH  LO register (quotient)
// - busy      out  1      divide in flight
// - stall     out  1      combinational: busy & (op_valid | mf_req)
// - div_zero  out  1      one-cycle pulse when a divide with rt_val==0 completes
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; hi=0, lo=0; busy=0, div_zero=0; core counter=0.
// - FSM: IDLE -> SETUP -> ITER (WIDTH cycles) -> FIXUP -> IDLE.
// - Accept: op_valid & !busy & !flush in IDLE.
//   - DIV/DIVU: latch rs/rt and sign bits; next state SETUP.
//   - MTHI/MTLO: write hi/lo at that edge; stay IDLE; no busy.
// - SETUP: for DIV load |rs|, |rt| into the core, else raw values; pulse core start.
// - ITER: each cycle the core shifts the partial remainder left 1 and subtracts the divisor.
//   - Non-negative difference -> keep it, quotient bit=1; else quotient bit=0.
//   - Counter decrements; leave ITER when the core's done is set (counter==0).
// - FIXUP (DIV only):
//   - Quotient negated when sign(rs)!=sign(rt).
//   - Remainder negated when rs negative.
//   - hi/lo written at the edge ending FIXUP; div_zero pulses in that cycle if rt==0.
// - Latency: accept edge N; busy=1 for cycles N+1..N+WIDTH+2 (34 at default); new hi/lo visible in cycle N+WIDTH+3.
// - hi/lo never change mid-divide; MFHI/MFLO during busy stall until busy falls, then read new values.
// - op_valid while busy: stall=1, op not accepted; decode holds the op; accepted in first IDLE cycle.
// - Divide by zero: no special path, fixed latency.
//   - DIVU: lo=all-ones, hi=rs.
//   - DIV: lo=(rs<0 ? 1 : all-ones), hi=rs.
// - Overflow, DIV 0x80000000 / -1: lo=0x80000000, hi=0, no flag.
// - flush: any state -> IDLE next edge; hi/lo unchanged; busy=0 next cycle.
//   - flush with op_valid in IDLE: op dropped.
// - All arithmetic is WIDTH-bit unsigned in the core; the core partial remainder is WIDTH+1 bits.
//   - Sign of the difference is its MSB.
// STRUCTURE
// - mdu_pkg: mdu_op_t enum, div_state_t enum {IDLE,SETUP,ITER,FIXUP}, localparam DIV_CYCLES=WIDTH.
// - Sub-module div_iter_core(clk, reset_n, start, dividend, divisor, quot, rem, done).
//   - Unsigned, one bit per cycle, counter-terminated.
//   - Controller owns sign handling, FSM, HI/LO and stall.
// TESTING
// - DIVU 100/7 -> stall while busy; after 34 busy cycles lo=14, hi=2, div_zero=0.
// - DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
// - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero pulse 1 cycle; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
// - MTLO 0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0.
//   - MTHI held during busy -> stall=1 each cycle, accepted in the first IDLE cycle.
// - flush at ITER cycle 10 of DIVU 100/7 -> IDLE next cycle, hi/lo keep prior values, no div_zero.
// - reset_n low mid-ITER (asynchronous, between edges) -> hi=lo=0, busy=0 immediately; next DIVU 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO divide unit: decode op codes, sequencer states and
// the default iteration count.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_DIVU = 2'd0,
        OP_DIV  = 2'd1,
        OP_MTHI = 2'd2,
        OP_MTLO = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        FIXUP = 2'd3
    } div_state_t;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider, one quotient bit per clock, terminated by a down-counter.
// The start edge performs the first step, so WIDTH-1 further steps remain afterwards.
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quot_q, rem_q, dsr_q;
    logic [WIDTH-1:0] src_quot, src_rem, src_dsr;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] nxt_quot, nxt_rem;

    // The partial remainder is shifted into WIDTH+1 bits; the difference MSB is its sign.
    always_comb begin
        src_quot = start ? dividend : quot_q;
        src_rem  = start ? '0 : rem_q;
        src_dsr  = start ? divisor : dsr_q;
        shifted  = {src_rem, src_quot[WIDTH-1]};
        diff     = shifted - {1'b0, src_dsr};
        nxt_quot = {src_quot[WIDTH-2:0], ~diff[WIDTH]};
        nxt_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start || (cnt != '0)) begin
            quot_q <= nxt_quot;
            rem_q  <= nxt_rem;
        end
        if (start) begin
            dsr_q <= divisor;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign done = (cnt == '0);

endmodule

// File: rtl/divu_seq_ctrl.sv
// HI/LO divide sequencer: accepts DIV/DIVU/MTHI/MTLO, runs the iterative core,
// applies the signed fix-up, owns HI/LO and stalls decode while a divide is in flight.
module divu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             div_zero
);

    div_state_t state, state_nxt;
    mdu_op_t    op;

    logic signed [WIDTH-1:0] rs_q, rt_q;
    logic                    signed_q;
    logic                    rs_neg, rt_neg, rt_zero;
    logic                    accept, is_div;
    logic                    core_start, core_done;
    logic [WIDTH-1:0]        core_dividend, core_divisor, core_quot, core_rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign op      = mdu_op_t'(op_code);
    assign is_div  = (op == OP_DIVU) || (op == OP_DIV);
    assign accept  = op_valid && !flush && (state == IDLE);
    assign rs_neg  = signed_q && rs_q[WIDTH-1];
    assign rt_neg  = signed_q && rt_q[WIDTH-1];
    assign rt_zero = (rt_q == '0);

    assign core_dividend = cond_neg(rs_q, rs_neg);
    assign core_divisor  = cond_neg(rt_q, rt_neg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        case (state)
            IDLE:    if (accept && is_div) state_nxt = SETUP;
            SETUP: begin
                core_start = 1'b1;
                state_nxt  = ITER;
            end
            ITER:    if (core_done) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign busy     = (state != IDLE);
    assign stall    = busy && (op_valid || mf_req);
    assign div_zero = (state == FIXUP) && rt_zero && !flush;

    always_ff @(posedge clk) begin
        if (accept && is_div) begin
            rs_q     <= rs_val;
            rt_q     <= rt_val;
            signed_q <= (op == OP_DIV);
        end
    end

    // HI/LO change only on the FIXUP edge or an idle MTHI/MTLO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == FIXUP) && !flush) begin
            lo <= cond_neg(core_quot, rs_neg ^ rt_neg);
            hi <= cond_neg(core_rem, rs_neg);
        end else if (accept && (op == OP_MTHI)) begin
            hi <= rs_val;
        end else if (accept && (op == OP_MTLO)) begin
            lo <= rs_val;
        end
    end

    div_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (core_start),
        .dividend(core_dividend),
        .divisor (core_divisor),
        .quot    (core_quot),
        .rem     (core_rem),
        .done    (core_done)
    );

endmodule

// File: tb/tb_divu_seq_ctrl.sv
// Directed self-checking bench for divu_seq_ctrl with hand-computed expectations.
module tb_divu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mf_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall, div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divu_seq_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op_valid(op_valid),
        .op_code (op_code),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mf_req  (mf_req),
        .flush   (flush),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .div_zero(div_zero)
    );

    // Present an op for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    // Issue a divide with MFxx pending and count busy / stall / div_zero cycles.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int bcnt, output int scnt, output int dcnt, output logic stall_after);
        issue(op, a, b);
        mf_req = 1'b1;
        bcnt = 0; scnt = 0; dcnt = 0;
        while (busy && bcnt < 100) begin
            bcnt++;
            if (stall) scnt++;
            if (div_zero) dcnt++;
            @(posedge clk); #1;
        end
        stall_after = stall;
        mf_req = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", div_zero); end
        mf_req = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        mf_req = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_divu;
        int b, s, d; logic sa;
        run_div(2'd0, 32'd100, 32'd7, b, s, d, sa);
        checks++; if (b != 34) begin errors++; $display("FAIL divu_busy_cycles got %0d want 34", b); end
        checks++; if (s != 34) begin errors++; $display("FAIL divu_stall_cycles got %0d want 34", s); end
        checks++; if (sa !== 1'b0) begin errors++; $display("FAIL divu_stall_after got %b want 0", sa); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'd2); end
        checks++; if (d != 0) begin errors++; $display("FAIL divu_divzero got %0d want 0", d); end
    endtask

    task automatic test_div_signed;
        int b, s, d; logic sa;
        run_div(2'd1, 32'hFFFF_FFF9, 32'd2, b, s, d, sa);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo got %h want FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi got %h want FFFFFFFF", hi); end
        run_div(2'd1, 32'd7, 32'hFFFF_FFFE, b, s, d, sa);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo got %h want FFFFFFFD", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_7_m2_hi got %h want 00000001", hi); end
        checks++; if (b != 34) begin errors++; $display("FAIL div_busy_cycles got %0d want 34", b); end
    endtask

    task automatic test_div_zero;
        int b, s, d; logic sa;
        run_div(2'd0, 32'd5, 32'd0, b, s, d, sa);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_z_lo got %h want FFFFFFFF", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu_z_hi got %h want 00000005", hi); end
        checks++; if (d != 1) begin errors++; $display("FAIL divu_z_pulse got %0d want 1", d); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divu_z_after got %b want 0", div_zero); end
        checks++; if (b != 34) begin errors++; $display("FAIL divu_z_busy got %0d want 34", b); end
        run_div(2'd1, 32'hFFFF_FFFB, 32'd0, b, s, d, sa);
        checks++; if (lo !== 32'd1) begin errors++; $display("FAIL div_z_lo got %h want 00000001", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div_z_hi got %h want FFFFFFFB", hi); end
        checks++; if (d != 1) begin errors++; $display("FAIL div_z_pulse got %0d want 1", d); end
    endtask

    task automatic test_overflow;
        int b, s, d; logic sa;
        run_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, b, s, d, sa);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi); end
        checks++; if (d != 0) begin errors++; $display("FAIL ovf_divzero got %0d want 0", d); end
    endtask

    task automatic test_mt;
        issue(2'd3, 32'h1234, 32'h0);
        checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got %h want 00001234", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b want 0", busy); end
        issue(2'd2, 32'hABCD, 32'h0);
        checks++; if (hi !== 32'hABCD) begin errors++; $display("FAIL mthi_hi got %h want 0000ABCD", hi); end
        checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mthi_lo_kept got %h want 00001234", lo); end
    endtask

    task automatic test_back_to_back;
        int b = 0, s = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 2'd0; rs_val = 32'd9; rt_val = 32'd2;
        @(posedge clk); #1;
        op_code = 2'd2; rs_val = 32'h55; rt_val = 32'h0;
        while (busy && b < 100) begin
            b++;
            if (stall) s++;
            @(posedge clk); #1;
        end
        checks++; if (s != 34) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 34", s); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_idle got %b want 0", stall); end
        checks++; if (hi !== 32'd1 || lo !== 32'd4) begin errors++; $display("FAIL b2b_div got hi=%h lo=%h want 1/4", hi, lo); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if (hi !== 32'h55) begin errors++; $display("FAIL b2b_mthi got %h want 00000055", hi); end
        checks++; if (lo !== 32'd4 || busy !== 1'b0) begin errors++; $display("FAIL b2b_after got lo=%h busy=%b want 4/0", lo, busy); end
    endtask

    task automatic test_flush;
        int d = 0;
        issue(2'd0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", busy); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (div_zero || busy) d++;
            @(posedge clk); #1;
        end
        checks++; if (d != 0) begin errors++; $display("FAIL flush_activity got %0d want 0", d); end
        checks++; if (hi !== 32'h55 || lo !== 32'd4) begin errors++; $display("FAIL flush_hilo got hi=%h lo=%h want 55/4", hi, lo); end
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 2'd3; rs_val = 32'h777; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        checks++; if (lo !== 32'd4) begin errors++; $display("FAIL flush_drop_mtlo got %h want 00000004", lo); end
    endtask

    task automatic test_async_reset;
        int b, s, d; logic sa;
        issue(2'd0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL areset_hilo got hi=%h lo=%h want 0/0", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        #10;
        reset_n = 1'b1;
        run_div(2'd0, 32'd9, 32'd3, b, s, d, sa);
        checks++; if (lo !== 32'd3 || hi !== 32'd0) begin errors++; $display("FAIL areset_div got lo=%h hi=%h want 3/0", lo, hi); end
        checks++; if (b != 34) begin errors++; $display("FAIL areset_busy_cycles got %0d want 34", b); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_mt();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
